// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 8x16 register file: round-robin arbitration of the
// ALU and load writeback ports plus a per-register pending-write scoreboard.

module regfile_wr_sched_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt,
    output logic       err
);
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (inc && !dec) begin
            if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
        end else if (dec && !inc) begin
            if (cnt_q == 2'd0) err = 1'b1;
            else               cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 2'd0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

module regfile_wr_sched #(
    parameter int AW   = 3,
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,
    output logic            b_ready,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_ready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [NREG-1:0] busy,
    output logic            sb_err
);
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    port_e               last_q, last_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DW-1:0]       wr_data_q, wr_data_d;
    logic                sb_err_q, sb_err_d;
    wr_req_t             win;
    logic                xfer, commit, rsv_fire;
    logic [NREG-1:0][1:0] cnt;
    logic [NREG-1:0]     err_vec;

    // Loser of the previous grant wins a tie.
    always_comb begin
        a_ready   = a_valid && (!b_valid || last_q == PORT_B);
        b_ready   = b_valid && (!a_valid || last_q == PORT_A);
        xfer      = a_ready || b_ready;
        win       = a_ready ? wr_req_t'{a_addr, a_data} : wr_req_t'{b_addr, b_data};
        commit    = xfer && (win.addr != '0);
        rsv_ready = (cnt[rsv_addr] != 2'd3);
        rsv_fire  = rsv_valid && rsv_ready && (rsv_addr != '0);
    end

    always_comb begin
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        sb_err_d  = sb_err_q || (|err_vec);
        if (a_ready)      last_d = PORT_A;
        else if (b_ready) last_d = PORT_B;
        // r0 writes complete the handshake but never reach the register file.
        if (xfer) begin
            wr_en_d   = commit;
            wr_addr_d = win.addr;
            wr_data_d = win.data;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_reg
            regfile_wr_sched_cnt u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (rsv_fire && rsv_addr == AW'(g)),
                .dec   (commit && win.addr == AW'(g)),
                .cnt   (cnt[g]),
                .err   (err_vec[g])
            );
            assign busy[g] = (cnt[g] != 2'd0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= PORT_B;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign sb_err  = sb_err_q;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Scoreboard bench for regfile_wr_sched: a reference model predicts grants, writes and
// scoreboard state; expected writes are queued at drive time and popped as wr_en fires.

module tb_regfile_wr_sched;
    localparam int AW = 3, DW = 16, NREG = 8;

    logic clk = 1'b0, rst_n;
    logic a_valid, b_valid, rsv_valid;
    logic [AW-1:0] a_addr, b_addr, rsv_addr, wr_addr;
    logic [DW-1:0] a_data, b_data, wr_data;
    logic a_ready, b_ready, rsv_ready, wr_en, sb_err;
    logic [NREG-1:0] busy;

    regfile_wr_sched #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  m_cnt[NREG];
    bit  m_last;  // 1: B won last grant
    bit  m_err;
    int  n_tests = 0, n_fail = 0;
    logic [DW-1:0] rf[NREG];

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] b;
        for (int i = 0; i < NREG; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        m_last = 1'b1;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    // Register file stand-in: captures on the falling edge inside the write cycle.
    always @(negedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    always @(posedge clk) begin : monitor
        wr_t e;
        #1;
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic step(bit av, logic [AW-1:0] aa, logic [DW-1:0] ad,
                        bit bv, logic [AW-1:0] ba, logic [DW-1:0] bd,
                        bit rv, logic [AW-1:0] ra);
        bit ga, gb, rr, we;
        logic [AW-1:0] wa;
        int inc_r, dec_r;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rsv_valid = rv; rsv_addr = ra;
        #1;
        ga = av && (!bv || m_last);
        gb = bv && (!av || !m_last);
        rr = (m_cnt[ra] != 3);
        check("a_ready", 32'(a_ready), 32'(ga));
        check("b_ready", 32'(b_ready), 32'(gb));
        check("rsv_ready", 32'(rsv_ready), 32'(rr));
        wa = ga ? aa : ba;
        we = (ga || gb) && wa != 0;
        if (we) exp_q.push_back('{wa, ga ? ad : bd});
        inc_r = (rv && rr && ra != 0) ? int'(ra) : -1;
        dec_r = we ? int'(wa) : -1;
        @(posedge clk); #1;
        if (ga) m_last = 1'b0; else if (gb) m_last = 1'b1;
        if (inc_r != dec_r) begin
            if (inc_r >= 0) m_cnt[inc_r]++;
            if (dec_r >= 0) begin
                if (m_cnt[dec_r] == 0) m_err = 1'b1;
                else m_cnt[dec_r]--;
            end
        end
        check("wr_en", 32'(wr_en), 32'(we));
        check("busy", 32'(busy), 32'(exp_busy()));
        check("sb_err", 32'(sb_err), 32'(m_err));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        model_reset();
        // Reset with random inputs
        rst_n = 1'b0;
        a_valid = 1'($urandom); a_addr = AW'($urandom); a_data = DW'($urandom);
        b_valid = 1'($urandom); b_addr = AW'($urandom); b_data = DW'($urandom);
        rsv_valid = 1'($urandom); rsv_addr = AW'($urandom);
        #23;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sb_err", 32'(sb_err), 32'd0);
        a_valid = 0; b_valid = 0; rsv_valid = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(); idle();

        // Single write through A
        step(0, 0, 0, 0, 0, 0, 1, 3);
        step(1, 3, 16'h1234, 0, 0, 0, 0, 0);
        #5;
        check("rf_r3", 32'(rf[3]), 32'h1234);

        // r0 reservation and write
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 16'hFFFF, 0, 0);
        #5;
        check("rf_r0", 32'(rf[0]), 32'h0);

        // Contention: expect A,B,A,B with continuous wr_en
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 1, 2);
        for (int i = 0; i < 4; i++)
            step(1, 1, DW'(16'hA000 + i), 1, 2, DW'(16'hB000 + i), 0, 0);
        idle();

        // Scoreboard boundaries on r5
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 5);
        step(1, 5, 16'h0051, 0, 0, 0, 0, 0);
        step(1, 5, 16'h0052, 0, 0, 0, 1, 5);
        step(0, 0, 0, 1, 5, 16'h0053, 0, 0);
        step(1, 5, 16'h0054, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 16'h0055, 0, 0);
        idle(); idle();
        check("sb_err_sticky", 32'(sb_err), 32'd1);

        // Reset during a registered write
        step(0, 0, 0, 0, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 0, 1, 4);
        step(1, 4, 16'hBEEF, 0, 0, 0, 0, 0);
        a_valid = 0; b_valid = 0; rsv_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sb_err", 32'(sb_err), 32'd0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 1, 6, 16'h0066, 1, 6);
        step(1, 7, 16'h0077, 0, 0, 0, 0, 0);
        idle(); idle();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler and pending-write scoreboard for the 8×16 register file. Two writeback sources share the register file's single write port: the ALU path (port A) and the memory/load path (port B). The block arbitrates between them round-robin and drives the register file's `wrenable`/`a3`/`wr` inputs from registers. It also keeps a per-register count of outstanding writes, so the issue stage can stall on RAW hazards.

## Interface
Parameters:
- AW, 3, register address width
- DW, 16, data width
- NREG, 8, number of registers (must equal 2**AW)

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- a_valid  in  1  ALU writeback request.
- a_addr  in  AW  ALU destination register.
- a_data  in  DW  ALU result.
- a_ready  out  1  ALU request accepted this cycle.
- b_valid  in  1  memory writeback request.
- b_addr  in  AW  memory destination register.
- b_data  in  DW  load data.
- b_ready  out  1  memory request accepted this cycle.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_addr  in  AW  register being reserved.
- rsv_ready  out  1  reservation accepted.
- wr_en  out  1  to register file `wrenable`.
- wr_addr  out  AW  to register file `a3`.
- wr_data  out  DW  to register file `wr`.
- busy  out  NREG  bit i is high when register i has at least one outstanding write.
- sb_err  out  1  sticky: a write committed to a register with no outstanding reservation.

## Operation
- **Handshake.** A transfer occurs on a rising edge where valid and ready are both high. A requester holds valid, addr and data stable until ready is seen. `a_ready`/`b_ready` are combinational from the valids and the arbiter state. At most one of them is high in any cycle.
- **Arbitration.** The block grants one request per cycle.
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the port that did not win the most recent grant.
  - `last` is a 1-bit state updated on every transfer. Its reset value is B, so A wins the first contention.
- **Write output.** On a transfer, the next edge registers the write: `wr_en`=1 with the winner's addr and data. With no transfer, `wr_en`=0 and `wr_addr`/`wr_data` hold their previous values.
  - Writes to address 0 complete the handshake but force `wr_en`=0, so r0 stays 0.
- **Scoreboard.** Each register has a 2-bit counter `cnt[i]`, saturating at 3; `busy[i]` = (`cnt[i]`≠0).
  - **Reserve.** `rsv_valid` & `rsv_ready` & `rsv_addr`≠0 increments `cnt[rsv_addr]`.
    - `rsv_ready` = (`cnt[rsv_addr]`≠3), combinational.
    - A reservation of r0 is always ready and has no effect.
  - **Commit.** A transfer with addr≠0 decrements `cnt[addr]`.
    - If that counter is 0 it stays 0 and `sb_err` sets. `sb_err` clears only on reset.
  - **Reserve and commit on the same register in the same cycle:** the count is unchanged. `rsv_ready` is evaluated on the pre-edge count.
  - Reserve and commit on different registers update independently.

## Timing
- **Reset values** (rst_n low, asynchronous):
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - all `cnt`=0, so `busy`=0.
  - `sb_err`=0, `last`=B.
  - `a_ready`/`b_ready` follow the valids combinationally and are therefore gated only by the arbiter.
- **Reset mid-operation** drops any pending registered write (`wr_en`→0 immediately) and clears the scoreboard. In-flight requests must re-present after reset.
- **Latency and port timing:**
  - Handshake at edge N → `wr_en` high from edge N to edge N+1.
  - The register file captures the write at the falling edge between N and N+1; read ports see the new value from that falling edge.
  - `busy` falls at edge N, the same edge as the transfer. Issue logic may therefore read the register after the falling edge of that cycle.
- **Throughput:** one write per cycle. Under sustained contention A and B alternate, each receiving 50% of grants.
- **Ready timing:** a requester that is not granted sees ready=0 and must retry the next cycle. There is no starvation beyond 1 cycle.
- **Reservation timing:** a reservation at edge N makes `busy` high after edge N.

## Test plan
- **Reset:** rst_n=0 with all inputs random → `wr_en`=0, `busy`=8'h00, `sb_err`=0. Release reset → state unchanged until the first request.
- **Single write:** reserve r3, then A writes r3=16'h1234 → `busy[3]`=1 for 1 cycle; `a_ready`=1; next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=16'h1234; register file r3 reads 16'h1234 after the falling edge; `busy[3]`=0.
- **Contention:** A and B both valid for 4 cycles (A→r1, B→r2, with fresh data each cycle) → grants A,B,A,B; `wr_en` stays high continuously; writes appear in that order.
- **r0 handling:** reserve r0, then B writes r0=16'hFFFF → `rsv_ready`=1, `busy`=0, `b_ready`=1, `wr_en` stays 0, r0 reads 0.
- **Scoreboard boundaries:**
  - Reserve r5 three times → `cnt`=3 and `rsv_ready`=0 on a 4th attempt.
  - Reserve r5 and commit r5 in the same cycle → `busy[5]` stays 1 and `cnt` is unchanged.
  - Three commits → `busy[5]`=0.
  - A 4th commit → `sb_err`=1, which stays high.
- **Reset mid-write:** handshake at edge N, assert rst_n low before edge N+1 → `wr_en` drops immediately and all `busy` bits clear.
